// File: rtl/ssd_scan_ctrl_if.sv
// Bundles the value/handshake inputs and the scanned SSD pin outputs of ssd_scan_ctrl.
// master drives the value and live controls; slave is the display controller side.
interface ssd_scan_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 10
);
    logic [BIN_W-1:0]  din;
    logic              load;
    logic              hex_mode;
    logic              blank_lz;
    logic [DIGITS-1:0] dp_in;
    logic              busy;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;

    modport master (
        output din, load, hex_mode, blank_lz, dp_in,
        input  busy, an, seg, dp
    );

    modport slave (
        input  din, load, hex_mode, blank_lz, dp_in,
        output busy, an, seg, dp
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Purpose: binary-to-decimal/hex seven-segment scan controller with blanking, DPs and overflow dashes.
// Latency: decimal load busy BIN_W+1 cycles then commits atomically; hex load commits the same edge.
// Backpressure: load is dropped (not queued) while busy; scan outputs change only on prescaler ticks.
module ssd_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 10,
    parameter int REFRESH_DIV = 50000
) (
    input logic          CLK,
    input logic          RST_N,
    ssd_scan_ctrl_if.slave bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam int PRE_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WIDE_W = (BIN_W > BCD_W) ? BIN_W : BCD_W;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t            state_q,    state_d;
    logic [BIN_W-1:0]  shreg_q,    shreg_d;
    logic [BCD_W-1:0]  bcd_q,      bcd_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              acc_ovf_q,  acc_ovf_d;
    logic              busy_q,     busy_d;
    logic [BCD_W-1:0]  disp_q,     disp_d;
    logic              disp_ovf_q, disp_ovf_d;

    logic [PRE_W-1:0]  presc_q,    presc_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [DIGITS-1:0] an_q,       an_d;
    logic [6:0]        seg_q,      seg_d;
    logic              dp_q,       dp_d;

    logic [BCD_W-1:0]  bcd_adj;
    logic [WIDE_W-1:0] din_wide;
    logic              tick;
    logic [3:0]        cur_nib;
    logic              upper_zero;
    logic [6:0]        seg_sel;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Conversion FSM: double-dabble runs in bcd_q, display register only moves on commit/hex load
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        acc_ovf_d  = acc_ovf_q;
        busy_d     = busy_q;
        disp_d     = disp_q;
        disp_ovf_d = disp_ovf_q;
        din_wide   = WIDE_W'(bus.din);

        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    if (bus.hex_mode) begin
                        disp_d     = din_wide[BCD_W-1:0];
                        disp_ovf_d = |(din_wide >> BCD_W);
                    end else begin
                        shreg_d   = bus.din;
                        bcd_d     = '0;
                        cnt_d     = '0;
                        acc_ovf_d = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // A set top bit after add-3 means the doubled value reaches 10^DIGITS
                bcd_d     = {bcd_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
                shreg_d   = shreg_q << 1;
                acc_ovf_d = acc_ovf_q | bcd_adj[BCD_W-1];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d     = bcd_q;
                disp_ovf_d = acc_ovf_q;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Scan: the digit selected by idx_q is latched on the tick edge while idx_q steps on
    always_comb begin
        tick    = (presc_q == PRE_W'(REFRESH_DIV - 1));
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        cur_nib    = disp_q[{idx_q, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if ((j >= int'(idx_q)) && (disp_q[4*j +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end

        if (disp_ovf_q) begin
            seg_sel = SEG_DASH;
        end else if (bus.blank_lz && (idx_q != '0) && upper_zero) begin
            seg_sel = SEG_BLANK;
        end else begin
            seg_sel = seg_decode(cur_nib);
        end

        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (tick) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = seg_sel;
            dp_d  = ~bus.dp_in[idx_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            acc_ovf_q  <= 1'b0;
            busy_q     <= 1'b0;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            acc_ovf_q  <= acc_ovf_d;
            busy_q     <= busy_d;
            disp_q     <= disp_d;
            disp_ovf_q <= disp_ovf_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = dp_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed and randomized checks of two ssd_scan_ctrl instances (4-digit/10-bit and 3-digit/14-bit)
// against an arithmetic model of the expected digit patterns.
module tb_ssd_scan_ctrl;

    localparam int RD = 4;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    ssd_scan_ctrl_if #(.DIGITS(4), .BIN_W(10)) if4 ();
    ssd_scan_ctrl_if #(.DIGITS(3), .BIN_W(14)) if3 ();

    ssd_scan_ctrl #(.DIGITS(4), .BIN_W(10), .REFRESH_DIV(RD)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .bus(if4.slave)
    );
    ssd_scan_ctrl #(.DIGITS(3), .BIN_W(14), .REFRESH_DIV(RD)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .bus(if3.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic       sel3 = 1'b0;
    logic [7:0] an_m;
    logic [6:0] seg_m;
    logic       dp_m;
    logic       busy_m;
    logic [6:0] exp_seg [8];
    logic       exp_dp  [8];

    always_comb begin
        an_m   = sel3 ? {5'h1F, if3.an} : {4'hF, if4.an};
        seg_m  = sel3 ? if3.seg  : if4.seg;
        dp_m   = sel3 ? if3.dp   : if4.dp;
        busy_m = sel3 ? if3.busy : if4.busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    // Expected pattern per digit from the displayed number itself
    function automatic void model(input int v, input bit hex, input int nd, input bit blank,
                                  input logic [7:0] dpin);
        int  base = hex ? 16 : 10;
        int  lim  = 1;
        int  pw   = 1;
        bit  ovf;
        for (int i = 0; i < nd; i++) lim *= base;
        ovf = (v >= lim);
        for (int i = 0; i < 8; i++) begin
            exp_seg[i] = 7'h7F;
            exp_dp[i]  = 1'b1;
        end
        for (int i = 0; i < nd; i++) begin
            if (ovf)                          exp_seg[i] = 7'b0111111;
            else if (blank && i > 0 && v < pw) exp_seg[i] = 7'h7F;
            else                              exp_seg[i] = seg_of((v / pw) % base);
            exp_dp[i] = ~dpin[i];
            pw *= base;
        end
    endfunction

    task automatic set_live(input bit blank, input logic [7:0] dpin);
        if4.blank_lz = blank;
        if4.dp_in    = dpin[3:0];
        if3.blank_lz = blank;
        if3.dp_in    = dpin[2:0];
    endtask

    task automatic do_load(input int v, input bit hex);
        if (sel3) begin
            if3.din = 14'(v); if3.hex_mode = hex; if3.load = 1'b1;
        end else begin
            if4.din = 10'(v); if4.hex_mode = hex; if4.load = 1'b1;
        end
        cyc(1);
        if3.load = 1'b0;
        if4.load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_m && n < 200) begin
            cyc(1);
            n++;
        end
        chk({tag, "_busy_timeout"}, busy_m, 0);
    endtask

    // Flush one scan, then check every digit slot of the next scan
    task automatic scan_check(input string tag);
        int nd = sel3 ? 3 : 4;
        bit seen [8];
        int hit;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        cyc(nd * RD + 4);
        for (int c = 0; c < nd * RD + 2; c++) begin
            cyc(1);
            hit = -1;
            for (int i = 0; i < nd; i++) begin
                if (an_m == ~(8'd1 << i)) hit = i;
            end
            chk({tag, "_an_onecold"}, (hit >= 0), 1);
            if (hit >= 0 && !seen[hit]) begin
                seen[hit] = 1'b1;
                chk($sformatf("%s_d%0d_seg", tag, hit), seg_m, exp_seg[hit]);
                chk($sformatf("%s_d%0d_dp", tag, hit), dp_m, exp_dp[hit]);
            end
        end
        for (int i = 0; i < nd; i++) chk($sformatf("%s_d%0d_seen", tag, i), seen[i], 1);
    endtask

    initial begin
        int n;
        int v;
        int v2;
        bit hex;
        bit blank;
        logic [7:0] dpin;

        RST_N = 1'b0;
        if4.din = '0; if4.hex_mode = 1'b0; if4.load = 1'b1;
        if3.din = '0; if3.hex_mode = 1'b0; if3.load = 1'b1;
        set_live(1'b0, 8'h00);
        cyc(3);
        chk("rst_an",   if4.an,   4'hF);
        chk("rst_seg",  if4.seg,  7'h7F);
        chk("rst_dp",   if4.dp,   1);
        chk("rst_busy", if4.busy, 0);
        chk("rst_busy3", if3.busy, 0);
        chk("rst_an3",  if3.an,   3'h7);

        // First tick after RD-1 edges, outputs move on the RD-th edge
        RST_N = 1'b1; if4.load = 1'b0; if3.load = 1'b0;
        cyc(RD - 1);
        chk("pre_tick_an", if4.an, 4'hF);
        cyc(1);
        chk("first_an",  if4.an,  4'b1110);
        chk("first_seg", if4.seg, 7'h40);
        chk("first_dp",  if4.dp,  1);

        sel3 = 1'b0;
        do_load(1023, 1'b0);
        n = 0;
        while (if4.busy && n < 100) begin
            n++;
            cyc(1);
        end
        chk("busy_len", n, 11);
        model(1023, 1'b0, 4, 1'b0, 8'h00);
        scan_check("dec1023");

        do_load(7, 1'b0);
        wait_idle("dec7");
        set_live(1'b1, 8'b0010);
        model(7, 1'b0, 4, 1'b1, 8'b0010);
        scan_check("blank7");
        set_live(1'b0, 8'b0010);
        model(7, 1'b0, 4, 1'b0, 8'b0010);
        scan_check("noblank7");

        set_live(1'b0, 8'h00);
        do_load(10'h2AF, 1'b1);
        chk("hex_busy0", if4.busy, 0);
        cyc(1);
        chk("hex_busy1", if4.busy, 0);
        model(10'h2AF, 1'b1, 4, 1'b0, 8'h00);
        scan_check("hex2af");

        sel3 = 1'b1;
        do_load(1000, 1'b0);
        wait_idle("ovf1000");
        model(1000, 1'b0, 3, 1'b0, 8'h00);
        scan_check("ovf1000");
        do_load(999, 1'b0);
        wait_idle("dec999");
        model(999, 1'b0, 3, 1'b1, 8'h00);
        set_live(1'b1, 8'h00);
        scan_check("dec999");
        do_load(14'h1ABC, 1'b1);
        model(14'h1ABC, 1'b1, 3, 1'b1, 8'h00);
        scan_check("hexovf");
        do_load(14'h00C, 1'b1);
        model(14'h00C, 1'b1, 3, 1'b1, 8'h00);
        scan_check("hexsmall");

        sel3 = 1'b0;
        set_live(1'b0, 8'h00);
        do_load(500, 1'b0);
        cyc(2);
        do_load(12, 1'b0);
        wait_idle("hs500");
        model(500, 1'b0, 4, 1'b0, 8'h00);
        scan_check("hs500");

        do_load(321, 1'b0);
        cyc(4);
        chk("abort_busy_before", if4.busy, 1);
        RST_N = 1'b0;
        cyc(1);
        chk("abort_busy", if4.busy, 0);
        chk("abort_an",   if4.an,   4'hF);
        RST_N = 1'b1;
        model(0, 1'b0, 4, 1'b0, 8'h00);
        scan_check("abort");

        for (int it = 0; it < 24; it++) begin
            sel3  = it[0];
            hex   = 1'($urandom_range(0, 1));
            blank = 1'($urandom_range(0, 1));
            dpin  = 8'($urandom);
            if ($urandom_range(0, 1) == 1) v = $urandom_range(0, 150);
            else v = sel3 ? $urandom_range(0, 16383) : $urandom_range(0, 1023);
            set_live(blank, dpin);
            do_load(v, hex);
            if (!hex) begin
                v2 = $urandom_range(0, 1023);
                cyc($urandom_range(0, 5));
                do_load(v2, $urandom_range(0, 1) == 1);
            end
            wait_idle($sformatf("rnd%0d", it));
            model(v, hex, sel3 ? 3 : 4, blank, dpin);
            scan_check($sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Parametrised multiplexed seven-segment display controller. It converts a binary value to decimal (sequential double-dabble) or hexadecimal digits, holds the digits in an atomic display register, and scans a configurable number of common-anode digits. It supports leading-zero blanking, per-digit decimal points, overflow indication, and a load/busy handshake. It sits between the joystick/servo datapath and the board SSD pins and is used for on-board debug display.

## Interface
- DIGITS, 4: number of digits scanned; legal 1..8.
- BIN_W, 10: width of binary input; legal 1..27.
- REFRESH_DIV, 50000: CLK cycles per digit slot; legal ≥2.

- CLK  in  1: system clock (100 MHz), all logic on rising edge.
- RST_N  in  1: reset, synchronous, active-low.
- DIN  in  BIN_W: binary value to display.
- LOAD  in  1: single-cycle request to capture DIN/HEX_MODE.
- HEX_MODE  in  1: 1 = hexadecimal digits, 0 = decimal; sampled with LOAD.
- BLANK_LZ  in  1: 1 = blank leading zeros; live input, not sampled.
- DP_IN  in  DIGITS: decimal point per digit, 1 = lit; live input.
- BUSY  out  1: conversion in progress; LOAD ignored while high.
- AN  out  DIGITS: anodes, active-low, one-cold while scanning.
- SEG  out  7: cathodes {g,f,e,d,c,b,a}, active-low.
- DP  out  1: decimal-point cathode, active-low.

## Operation
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: LOAD=1 with HEX_MODE=0 captures DIN into the shift register, clears the BCD accumulator (4·DIGITS bits) and the shift counter, sets BUSY, and moves to SHIFT.
  - IDLE: LOAD=1 with HEX_MODE=1 writes DIN nibbles directly into the display register in one cycle. FSM stays in IDLE and BUSY stays 0.
  - SHIFT: one double-dabble step per cycle: add 3 to every BCD nibble ≥5, then shift left one bit, MSB of DIN first. After BIN_W steps, go to COMMIT.
  - COMMIT: write the accumulator to the display register in a single cycle (no torn digits), clear BUSY, return to IDLE.
- Overflow:
  - Decimal: value ≥ 10^DIGITS. Detected by carry-out from the top BCD nibble, sticky during SHIFT.
  - Hex: any DIN bit at or above position 4·DIGITS set.
  - On overflow, the display register overflow flag is set and every digit shows dash (SEG=7'b0111111).
- LOAD while BUSY: ignored, no queueing.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps. Tick is asserted when the count equals REFRESH_DIV-1.
  - On each tick, digit index advances 0→1→…→DIGITS-1→0.
- Output register, loaded on the cycle after a tick:
  - AN: bit[idx]=0, all other bits 1.
  - SEG: decode of display nibble[idx].
  - DP: ~DP_IN[idx].
- Decode:
  - 0–9 standard patterns (0=1000000, 7=1111000, 8=0000000).
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking: when BLANK_LZ=1, digit idx>0 shows SEG=7'h7F if it and all higher digits are zero. Digit 0 is never blanked. DP is unaffected by blanking.
- Blanking is overridden by overflow dashes.

## Timing
- Reset (RST_N=0 at a rising edge) values:
  - AN all 1, SEG=7'h7F, DP=1, BUSY=0.
  - FSM=IDLE, prescaler=0, idx=0, display register=0, overflow flag=0.
- Reset takes priority over LOAD and aborts a conversion in progress. The display register keeps its reset value (0), not partial data.
- First tick occurs REFRESH_DIV-1 cycles after reset release. AN/SEG/DP first leave their reset values one cycle later.
- Decimal latency: LOAD sampled at edge k, BUSY=1 from k through k+BIN_W. Display register is valid and BUSY=0 at edge k+BIN_W+1.
- Hex latency: display register valid at edge k+1.
- AN, SEG and DP always change on the same edge; no cross-digit ghosting.
- Display register update between ticks takes effect at the next tick.
- Full scan period is DIGITS·REFRESH_DIV cycles.

## Test plan
All scenarios use REFRESH_DIV=4 unless stated.
- Reset: hold RST_N=0 for 3 cycles with LOAD=1 → AN=4'hF, SEG=7'h7F, DP=1, BUSY=0; first AN=4'b1110 appears 4 cycles after release.
- Decimal: DIGITS=4, BIN_W=10, DIN=1023, LOAD pulse → BUSY high for exactly 11 cycles; scan shows d0=0110000(3), d1=0100100(2), d2=1000000(0), d3=1111001(1).
- Blanking and DP: DIN=7, BLANK_LZ=1, DP_IN=4'b0010 → d3..d1 SEG=7'h7F, d0=1111000; DP=0 only while AN=4'b1101. With BLANK_LZ=0, d3..d1 show 1000000.
- Overflow: DIGITS=3, DIN=1000 → all three digits SEG=0111111. A following load of DIN=999 → 9,9,9.
- Hex: HEX_MODE=1, DIN=10'h2AF, DIGITS=4 → d0=0001110(F), d1=0001000(A), d2=0100100(2), d3=1000000. BUSY never asserts.
- Handshake and abort: LOAD DIN=500, second LOAD DIN=12 at BUSY cycle 3 → display 500. A new LOAD DIN=321, with RST_N=0 at BUSY cycle 5 → BUSY=0 next cycle and display all zeros.
